// File: rtl/freq_meter_mc.sv
`timescale 1ns/1ps
// freq_meter_mc: multi-channel reciprocal frequency meter.
// Scans the enabled Xsig channels round-robin. Each measurement opens on a
// rise of the selected channel, runs a GATE_CYC pre-gate, closes on the next
// rise, then divides CLK_FREQ*Nx by Ns with a one-bit-per-cycle restoring
// divider. Results leave over a valid/ready handshake.
//
// Ports
//   Clk, Rst       clock, synchronous active-high reset
//   Xsig           asynchronous signals under test
//   Ch_en          channel enable mask
//   Cont, Start    continuous scan / single-sweep start pulse
//   Busy           measurement, division or output pending
//   Res_valid/_ready  result handshake
//   Res_ch, Res_freq, Res_ovf, Res_timeout  result payload
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for Start or Cont with a non-empty enable mask
// S_ARM   | waiting for the opening rise of the selected channel
// S_GATE  | pre-gate running, Ns and Nx counting
// S_CLOSE | pre-gate expired, waiting for the closing rise
// S_DIV   | restoring division, one quotient bit per cycle
// S_OUT   | result presented, waiting for Res_ready
// S_NEXT  | advance pointer, decide ARM or IDLE
module freq_meter_mc #(
  parameter int          CH_NUM      = 4,
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int          GATE_CYC    = 50000000,
  parameter int          CNT_W       = 32,
  parameter int          RES_W       = 28,
  parameter int          TIMEOUT_CYC = 100000000,
  localparam int         CH_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [CH_NUM-1:0] Xsig,
  input  logic [CH_NUM-1:0] Ch_en,
  input  logic              Cont,
  input  logic              Start,
  output logic              Busy,
  output logic              Res_valid,
  input  logic              Res_ready,
  output logic [CH_W-1:0]   Res_ch,
  output logic [RES_W-1:0]  Res_freq,
  output logic              Res_ovf,
  output logic              Res_timeout
);

  localparam int NUM_W = CNT_W + 32;
  localparam int DIV_W = $clog2(NUM_W + 1);
  localparam logic [31:0] GATE_LD = 32'(GATE_CYC - 1);
  localparam logic [31:0] TMO_LD  = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_GATE, S_CLOSE, S_DIV, S_OUT, S_NEXT
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   ptr;
  logic [CNT_W-1:0]  nx, ns;
  logic              sat;
  logic [31:0]       gate_cnt, tmo_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [NUM_W-1:0]  div_q;
  logic [CNT_W-1:0]  div_rem;
  logic [CH_NUM-1:0] xs1, xs2, xs3, rise;

  // Start and stop edges share the synchroniser delay, so it cancels in Ns.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      xs1 <= '0;
      xs2 <= '0;
      xs3 <= '0;
    end else begin
      xs1 <= Xsig;
      xs2 <= xs1;
      xs3 <= xs2;
    end
  end

  assign rise = xs2 & ~xs3;

  logic sel_rise;
  assign sel_rise = rise[ptr];

  // Saturating increments; a full counter holds and flags overflow.
  logic             nx_full, ns_full;
  logic [CNT_W-1:0] nx_inc, ns_inc;
  assign nx_full = &nx;
  assign ns_full = &ns;
  assign nx_inc  = nx_full ? nx : nx + CNT_W'(1);
  assign ns_inc  = ns_full ? ns : ns + CNT_W'(1);

  // Restoring divider step: dividend bits stream out of the top of div_q
  // while quotient bits shift in at the bottom.
  logic [CNT_W:0]   div_sh;
  logic             div_ge;
  logic [CNT_W-1:0] div_rem_n;
  logic [NUM_W-1:0] div_q_n;
  logic             q_big;
  assign div_sh    = {div_rem, div_q[NUM_W-1]};
  assign div_ge    = div_sh >= {1'b0, ns};
  assign div_rem_n = div_ge ? CNT_W'(div_sh - {1'b0, ns}) : div_sh[CNT_W-1:0];
  assign div_q_n   = {div_q[NUM_W-2:0], div_ge};
  assign q_big     = |div_q_n[NUM_W-1:RES_W];

  // Channel search: first enabled at or after ptr (IDLE), and first enabled
  // strictly after ptr (NEXT). Wrap means the scan went back to a channel
  // index not above the current one.
  logic [CH_W-1:0] first_ptr, next_ptr;
  logic            first_ok, next_ok, next_wrap;
  int              idx;

  always_comb begin
    first_ptr = ptr;
    first_ok  = 1'b0;
    next_ptr  = ptr;
    next_ok   = 1'b0;
    next_wrap = 1'b0;
    idx       = 0;
    for (int i = 0; i < CH_NUM; i++) begin
      idx = int'(ptr) + i;
      if (idx >= CH_NUM) idx = idx - CH_NUM;
      if (!first_ok && Ch_en[idx[CH_W-1:0]]) begin
        first_ok  = 1'b1;
        first_ptr = idx[CH_W-1:0];
      end
    end
    for (int i = 1; i <= CH_NUM; i++) begin
      idx = int'(ptr) + i;
      if (idx >= CH_NUM) idx = idx - CH_NUM;
      if (!next_ok && Ch_en[idx[CH_W-1:0]]) begin
        next_ok   = 1'b1;
        next_ptr  = idx[CH_W-1:0];
        next_wrap = (int'(ptr) + i) >= CH_NUM;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      nx          <= '0;
      ns          <= '0;
      sat         <= 1'b0;
      gate_cnt    <= '0;
      tmo_cnt     <= '0;
      div_cnt     <= '0;
      div_q       <= '0;
      div_rem     <= '0;
      Busy        <= 1'b0;
      Res_valid   <= 1'b0;
      Res_ch      <= '0;
      Res_freq    <= '0;
      Res_ovf     <= 1'b0;
      Res_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if ((Start || Cont) && first_ok) begin
            ptr     <= first_ptr;
            state   <= S_ARM;
            Busy    <= 1'b1;
            tmo_cnt <= TMO_LD;
            nx      <= '0;
            ns      <= '0;
            sat     <= 1'b0;
          end
        end
        S_ARM: begin
          if (sel_rise) begin
            state    <= S_GATE;
            gate_cnt <= GATE_LD;
            nx       <= '0;
            ns       <= '0;
          end else if (tmo_cnt == '0) begin
            state       <= S_OUT;
            Res_valid   <= 1'b1;
            Res_ch      <= ptr;
            Res_freq    <= '0;
            Res_ovf     <= 1'b0;
            Res_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 32'd1;
          end
        end
        S_GATE: begin
          ns <= ns_inc;
          if (ns_full) sat <= 1'b1;
          if (sel_rise) begin
            nx <= nx_inc;
            if (nx_full) sat <= 1'b1;
          end
          if (gate_cnt == '0) begin
            state   <= S_CLOSE;
            tmo_cnt <= TMO_LD;
          end else begin
            gate_cnt <= gate_cnt - 32'd1;
          end
        end
        S_CLOSE: begin
          ns <= ns_inc;
          if (ns_full) sat <= 1'b1;
          if (sel_rise) begin
            // Closing rise counts into Nx; numerator uses the counted value.
            nx      <= nx_inc;
            if (nx_full) sat <= 1'b1;
            state   <= S_DIV;
            div_q   <= NUM_W'(CLK_FREQ) * NUM_W'(nx_inc);
            div_rem <= '0;
            div_cnt <= DIV_W'(NUM_W - 1);
          end else if (tmo_cnt == '0) begin
            state       <= S_OUT;
            Res_valid   <= 1'b1;
            Res_ch      <= ptr;
            Res_freq    <= '0;
            Res_ovf     <= 1'b0;
            Res_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 32'd1;
          end
        end
        S_DIV: begin
          div_q   <= div_q_n;
          div_rem <= div_rem_n;
          if (div_cnt == '0) begin
            state       <= S_OUT;
            Res_valid   <= 1'b1;
            Res_ch      <= ptr;
            Res_freq    <= (sat || q_big) ? '1 : div_q_n[RES_W-1:0];
            Res_ovf     <= sat || q_big;
            Res_timeout <= 1'b0;
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        S_OUT: begin
          if (Res_ready) begin
            Res_valid <= 1'b0;
            state     <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (next_ok) ptr <= next_ptr;
          if (!next_ok || (!Cont && next_wrap)) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
          end else begin
            state   <= S_ARM;
            tmo_cnt <= TMO_LD;
            nx      <= '0;
            ns      <= '0;
            sat     <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter_mc.sv
`timescale 1ns/1ps
module tb_freq_meter_mc;

  localparam int CH_NUM   = 2;
  localparam int CLK_FREQ = 1000;
  localparam int GATE_CYC = 100;
  localparam int CNT_W    = 32;
  localparam int RES_W    = 28;
  localparam int TMO      = 500;
  localparam int LAT      = CNT_W + 32;
  localparam int SYNC_LAT = 3;
  localparam int GATE8    = 1000;
  localparam int CNT8     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       xsig = '0, ch_en = '0;
  logic             cont = 1'b0, start = 1'b0, res_ready = 1'b0;
  logic             busy, res_valid, res_ovf, res_timeout;
  logic [0:0]       res_ch;
  logic [RES_W-1:0] res_freq;

  logic [1:0]       xs8 = '0;
  logic             cont8 = 1'b0;
  logic             busy8, valid8, ovf8, to8;
  logic [0:0]       ch8;
  logic [RES_W-1:0] freq8;

  freq_meter_mc #(.CH_NUM(CH_NUM), .CLK_FREQ(CLK_FREQ), .GATE_CYC(GATE_CYC),
                  .CNT_W(CNT_W), .RES_W(RES_W), .TIMEOUT_CYC(TMO)) u_dut (
    .Clk(clk), .Rst(rst), .Xsig(xsig), .Ch_en(ch_en), .Cont(cont), .Start(start),
    .Busy(busy), .Res_valid(res_valid), .Res_ready(res_ready), .Res_ch(res_ch),
    .Res_freq(res_freq), .Res_ovf(res_ovf), .Res_timeout(res_timeout));

  freq_meter_mc #(.CH_NUM(CH_NUM), .CLK_FREQ(CLK_FREQ), .GATE_CYC(GATE8),
                  .CNT_W(CNT8), .RES_W(RES_W), .TIMEOUT_CYC(TMO)) u_dut8 (
    .Clk(clk), .Rst(rst), .Xsig(xs8), .Ch_en(2'b10), .Cont(cont8), .Start(1'b0),
    .Busy(busy8), .Res_valid(valid8), .Res_ready(1'b1), .Res_ch(ch8),
    .Res_freq(freq8), .Res_ovf(ovf8), .Res_timeout(to8));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Square-wave generators; a period update restarts the phase so every
  // rise after the update is exactly one period from the previous one.
  int per[2]     = '{0, 0};
  int per_new[2] = '{0, 0};
  bit upd[2]     = '{0, 0};
  int gcnt[2]    = '{0, 0};
  bit rise_hist[2][4096];

  initial begin
    logic nv;
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
        rise_hist[c][cyc % 4096] = 1'b0;
        if (upd[c]) begin
          per[c]  = per_new[c];
          upd[c]  = 1'b0;
          gcnt[c] = 0;
        end else if (per[c] != 0) begin
          gcnt[c]++;
          if (gcnt[c] >= per[c]) gcnt[c] = 0;
        end
        nv = (per[c] != 0) && (gcnt[c] < per[c] / 2);
        if (nv && !xsig[c]) rise_hist[c][cyc % 4096] = 1'b1;
        xsig[c] = nv;
      end
      xs8[1] = ~xs8[1];
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] mask;
    int p0, p1, rdly;
    int n;
    int ch_a; longint f_a; bit to_a;
    int ch_b; longint f_b; bit to_b;
  } vec_t;

  vec_t tbl[6];
  int   mptr = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic set_per(input int c, input int p);
    per_new[c] = p;
    upd[c]     = 1'b1;
  endtask

  task automatic get_result(input int exp_ch, input longint exp_freq, input bit exp_to,
                            input int rdly, output int v_edge);
    int n;
    bit ok;
    n = 0;
    v_edge = cyc;
    while (!res_valid && n < 3000) begin
      tick();
      n++;
    end
    if (!res_valid) begin
      checks++;
      errors++;
      $display("FAIL result_wait: no Res_valid within %0d cycles, expected ch %0d", n, exp_ch);
      return;
    end
    v_edge = cyc;
    check("res_ch", res_ch, exp_ch);
    check("res_freq", res_freq, exp_freq);
    check("res_ovf", res_ovf, 0);
    check("res_timeout", res_timeout, exp_to);
    if (!exp_to) begin
      // The closing rise reaches the FSM SYNC_LAT cycles after Xsig rises,
      // then the divider takes LAT cycles.
      checks++;
      if (!rise_hist[exp_ch][(cyc - LAT - SYNC_LAT) % 4096]) begin
        errors++;
        $display("FAIL div_latency: no ch%0d rise %0d cycles before Res_valid at cycle %0d",
                 exp_ch, LAT + SYNC_LAT, cyc);
      end
    end
    ok = 1'b1;
    for (int i = 0; i < rdly; i++) begin
      tick();
      if (!(res_valid && res_ch == exp_ch && res_freq == exp_freq && !res_ovf
            && res_timeout == exp_to)) ok = 1'b0;
    end
    if (rdly > 0) check("hold_stable", ok, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("valid_drop", res_valid, 0);
  endtask

  task automatic run_sweep(input vec_t v);
    int s, ve, ch, n;
    longint f;
    bit to;
    ch_en = v.mask;
    set_per(0, v.p0);
    set_per(1, v.p1);
    tick();
    tick();
    start = 1'b1;
    tick();
    s = cyc;
    start = 1'b0;
    for (int k = 0; k < v.n; k++) begin
      ch = (k == 0) ? v.ch_a : v.ch_b;
      f  = (k == 0) ? v.f_a  : v.f_b;
      to = (k == 0) ? v.to_a : v.to_b;
      get_result(ch, f, to, v.rdly, ve);
      if (to && k == 0) begin
        checks++;
        if (ve - s < TMO || ve - s > TMO + 2) begin
          errors++;
          $display("FAIL timeout_latency: got %0d cycles, expected %0d..%0d", ve - s, TMO, TMO + 2);
        end
      end
    end
    mptr = v.mask[0] ? 0 : 1;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check("busy_after_sweep", busy, 0);
    check("no_extra_result", res_valid, 0);
  endtask

  function automatic vec_t model_vec(input logic [1:0] m, input int p0, input int p1,
                                     input int rdly, input int ptr);
    vec_t v;
    int st, c;
    st = m[ptr] ? ptr : 1 - ptr;
    v = '{m, p0, p1, rdly, 0, 0, 0, 1'b0, 0, 0, 1'b0};
    for (int k = 0; k < 2; k++) begin
      c = st + k;
      if (c < 2 && m[c]) begin
        if (v.n == 0) begin
          v.ch_a = c;
          v.f_a  = (c == 0) ? CLK_FREQ / p0 : CLK_FREQ / p1;
        end else begin
          v.ch_b = c;
          v.f_b  = (c == 0) ? CLK_FREQ / p0 : CLK_FREQ / p1;
        end
        v.n++;
      end
    end
    return v;
  endfunction

  initial begin
    vec_t   rv;
    int     n, nres;
    bit     bb_ok;
    logic [1:0] m;
    longint all1;

    all1 = (longint'(1) << RES_W) - 1;
    //             mask   p0  p1 rdly n ch f    to ch f    to
    tbl[0] = '{2'b01, 10,  7,  0, 1, 0, 100, 0, 0, 0,   0};
    tbl[1] = '{2'b11, 10,  7,  0, 2, 0, 100, 0, 1, 142, 0};
    tbl[2] = '{2'b10, 10,  9, 50, 1, 1, 111, 0, 0, 0,   0};
    tbl[3] = '{2'b11,  5,  4,  2, 1, 1, 250, 0, 0, 0,   0};
    tbl[4] = '{2'b01,  0,  7,  0, 1, 0, 0,   1, 0, 0,   0};
    tbl[5] = '{2'b11,  3, 13,  1, 2, 0, 333, 0, 1, 76,  0};

    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_freq", res_freq, 0);
    check("rst_ch", res_ch, 0);
    check("rst_ovf", res_ovf, 0);
    check("rst_timeout", res_timeout, 0);

    for (int i = 0; i < 6; i++) run_sweep(tbl[i]);

    for (int i = 0; i < 8; i++) begin
      m  = 2'($urandom_range(1, 3));
      rv = model_vec(m, $urandom_range(3, 40), $urandom_range(3, 40),
                     $urandom_range(0, 6), mptr);
      run_sweep(rv);
    end

    // Reset in the middle of a gate
    ch_en = 2'b11;
    set_per(0, 10);
    set_per(1, 10);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (60) tick();
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_freq", res_freq, 0);
    check("mid_rst_ch", res_ch, 0);
    check("mid_rst_ovf", res_ovf, 0);
    check("mid_rst_timeout", res_timeout, 0);
    mptr = 0;
    run_sweep(model_vec(2'b11, 10, 6, 0, mptr));

    // Saturating instance, continuous scan of ch1 only
    cont8 = 1'b1;
    nres  = 0;
    bb_ok = 1'b1;
    n     = 0;
    while (nres < 3 && n < 6000) begin
      tick();
      n++;
      if (nres > 0 && !busy8) bb_ok = 1'b0;
      if (valid8) begin
        nres++;
        check("sat_ch", ch8, 1);
        check("sat_freq", freq8, (GATE8 >= (1 << CNT8)) ? all1 : 0);
        check("sat_ovf", ovf8, 1);
        check("sat_timeout", to8, 0);
      end
    end
    check("cont_results", nres, 3);
    check("cont_no_idle", bb_ok, 1);
    cont8 = 1'b0;
    n = 0;
    while (busy8 && n < 3000) begin
      tick();
      n++;
    end
    check("cont_stop", busy8, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
